// File: rtl/pc_sequencer.sv
// pc_sequencer: next fetch address generation with branch/jump redirect,
// hardware call/return stack, maskable interrupt entry and HALT handling.
module pc_sequencer #(
    parameter int                    PC_WIDTH    = 16,
    parameter int                    BR_IMM_W    = 6,
    parameter int                    J_IMM_W     = 12,
    parameter int                    STACK_DEPTH = 8,
    parameter logic [PC_WIDTH-1:0]   INT_VECTOR  = 16'h0010
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clk_en,
    input  logic                             branch_taken,
    input  logic [BR_IMM_W-1:0]              branch_imm,
    input  logic                             jump,
    input  logic                             jump_link,
    input  logic [J_IMM_W-1:0]               jump_imm,
    input  logic                             ret,
    input  logic                             halt_cmd,
    input  logic                             int_en_cmd,
    input  logic                             int_dis_cmd,
    input  logic                             int_req,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH):0]     stack_count,
    output logic                             int_active,
    output logic                             halted,
    output logic                             stack_ovf,
    output logic                             stack_unf
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]       FULL_C = CW'(STACK_DEPTH);
    localparam logic [CW-1:0]       ONE_C  = CW'(1);
    localparam logic [AW-1:0]       ONE_A  = AW'(1);
    localparam logic [PC_WIDTH-1:0] TWO_P  = PC_WIDTH'(2);

    logic [PC_WIDTH-1:0] pc_r, pc_nxt_s;
    logic [CW-1:0]       count_r, count_nxt_s;
    logic [CW-1:0]       level_r, level_nxt_s;
    logic                int_active_r, int_active_nxt_s;
    logic                int_en_r, int_en_nxt_s;
    logic                halted_r, halted_nxt_s;
    logic                ovf_r, ovf_nxt_s;
    logic                unf_r, unf_nxt_s;
    logic [PC_WIDTH-1:0] stack_r [STACK_DEPTH];

    logic [PC_WIDTH-1:0] seq_s, br_tgt_s, j_tgt_s, br_off_s, j_off_s, top_s;
    logic [PC_WIDTH-1:0] push_data_s;
    logic                push_s, push_we_s;
    logic                ret_s, jump_s, jl_s, br_s, redirect_s, int_take_s;
    logic [CW-1:0]       pop_count_s;

    // Target arithmetic: word offsets become byte offsets via the appended zero bit.
    assign br_off_s = {{(PC_WIDTH-BR_IMM_W-1){branch_imm[BR_IMM_W-1]}}, branch_imm, 1'b0};
    assign j_off_s  = {{(PC_WIDTH-J_IMM_W-1){jump_imm[J_IMM_W-1]}}, jump_imm, 1'b0};
    assign seq_s    = pc_r + TWO_P;
    assign br_tgt_s = seq_s + br_off_s;
    assign j_tgt_s  = seq_s + j_off_s;
    assign top_s    = stack_r[count_r[AW-1:0] - ONE_A];
    assign pop_count_s = count_r - ONE_C;

    // While halted, redirect commands are ignored and so do not block an interrupt.
    assign ret_s      = ret & ~halted_r;
    assign jump_s     = jump & ~halted_r;
    assign jl_s       = jump_link & ~halted_r;
    assign br_s       = branch_taken & ~halted_r;
    assign redirect_s = ret_s | jump_s | jl_s | br_s;
    assign int_take_s = int_req & int_en_r & ~int_active_r & ~redirect_s;
    assign push_we_s  = push_s & (count_r != FULL_C);

    // Next-state selection in priority order: interrupt, ret, jump(_link), branch, halt, seq.
    always_comb begin
        pc_nxt_s         = pc_r;
        count_nxt_s      = count_r;
        level_nxt_s      = level_r;
        int_active_nxt_s = int_active_r;
        halted_nxt_s     = halted_r;
        ovf_nxt_s        = ovf_r;
        unf_nxt_s        = unf_r;
        push_s           = 1'b0;
        push_data_s      = seq_s;

        if (int_take_s) begin
            push_s           = 1'b1;
            push_data_s      = halted_r ? pc_r : seq_s;
            pc_nxt_s         = INT_VECTOR;
            int_active_nxt_s = 1'b1;
            level_nxt_s      = count_r;
            halted_nxt_s     = 1'b0;
        end else if (ret_s) begin
            if (count_r != {CW{1'b0}}) begin
                pc_nxt_s    = top_s;
                count_nxt_s = pop_count_s;
                if (int_active_r && (pop_count_s == level_r)) begin
                    int_active_nxt_s = 1'b0;
                end else begin
                    int_active_nxt_s = int_active_r;
                end
            end else begin
                pc_nxt_s  = seq_s;
                unf_nxt_s = 1'b1;
            end
        end else if (jl_s) begin
            push_s   = 1'b1;
            pc_nxt_s = j_tgt_s;
        end else if (jump_s) begin
            pc_nxt_s = j_tgt_s;
        end else if (br_s) begin
            pc_nxt_s = br_tgt_s;
        end else if (halted_r) begin
            pc_nxt_s = pc_r;
        end else if (halt_cmd) begin
            halted_nxt_s = 1'b1;
        end else begin
            pc_nxt_s = seq_s;
        end

        if (push_s) begin
            if (count_r == FULL_C) begin
                ovf_nxt_s = 1'b1;
            end else begin
                count_nxt_s = count_r + ONE_C;
            end
        end else begin
            count_nxt_s = count_nxt_s;
        end

        if (int_dis_cmd) begin
            int_en_nxt_s = 1'b0;
        end else if (int_en_cmd) begin
            int_en_nxt_s = 1'b1;
        end else begin
            int_en_nxt_s = int_en_r;
        end
    end

    // Control state register; reset wins, clk_en low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= {PC_WIDTH{1'b0}};
            count_r      <= {CW{1'b0}};
            level_r      <= {CW{1'b0}};
            int_active_r <= 1'b0;
            int_en_r     <= 1'b0;
            halted_r     <= 1'b0;
            ovf_r        <= 1'b0;
            unf_r        <= 1'b0;
        end else if (clk_en) begin
            pc_r         <= pc_nxt_s;
            count_r      <= count_nxt_s;
            level_r      <= level_nxt_s;
            int_active_r <= int_active_nxt_s;
            int_en_r     <= int_en_nxt_s;
            halted_r     <= halted_nxt_s;
            ovf_r        <= ovf_nxt_s;
            unf_r        <= unf_nxt_s;
        end
    end

    // Return-stack storage; entries are cleared on reset so no stale address is ever popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (clk_en && push_we_s) begin
            stack_r[count_r[AW-1:0]] <= push_data_s;
        end
    end

    assign pc          = pc_r;
    assign stack_count = count_r;
    assign int_active  = int_active_r;
    assign halted      = halted_r;
    assign stack_ovf   = ovf_r;
    assign stack_unf   = unf_r;
endmodule
